// File: rtl/rca_bist.sv
// Built-in self-test for a WIDTH-bit ripple-carry adder/subtractor: sweeps every
// {s,a,b} vector, compares against a golden sum/carry, and records mismatches.
module rca_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [15:0]        o_err_count,
    output logic [2*WIDTH:0]   o_first_fail,
    output logic [WIDTH-1:0]   o_dut_a,
    output logic [WIDTH-1:0]   o_dut_b,
    output logic               o_dut_s,
    input  logic [WIDTH-1:0]   i_dut_sum,
    input  logic               i_dut_cout
);

    // IDLE: wait for start | WAIT: adder settling | CHECK: compare and step | DONE: report
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_settle;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_s;
    logic               r_last_s;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [15:0]        r_err;
    logic [2*WIDTH:0]   r_first;

    logic               w_last_vec;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_gold;
    logic               w_mismatch;
    logic [15:0]        w_err_nxt;
    logic [2*WIDTH:0]   w_vec_inc;

    // Subtract is a + ~b + 1, so the carry-in is simply the mode bit.
    assign w_b_eff    = r_s ? ~r_b : r_b;
    assign w_gold     = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_s};
    assign w_mismatch = ({i_dut_cout, i_dut_sum} != w_gold);
    assign w_err_nxt  = (w_mismatch && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;
    assign w_last_vec = (&r_a) && (&r_b) && (r_s == r_last_s);
    assign w_vec_inc  = {r_s, r_a, r_b} + {{(2*WIDTH){1'b0}}, 1'b1};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (SETTLE == 0) ? S_CHECK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_settle == '0) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_last_vec) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = (SETTLE == 0) ? S_CHECK : S_WAIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_settle <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= 1'b0;
            r_last_s <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_first  <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_CHECK);
            r_done <= (w_state_nxt == S_DONE);

            if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
                r_settle <= SETTLE_LD;
            end else if ((r_state == S_WAIT) && (r_settle != '0)) begin
                r_settle <= r_settle - CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a      <= '0;
                        r_b      <= '0;
                        r_s      <= (i_mode == 2'b01);
                        r_last_s <= (i_mode != 2'b00);
                        r_err    <= '0;
                        r_pass   <= 1'b0;
                        r_first  <= '0;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_nxt;
                    if (w_mismatch && (r_err == '0)) begin
                        r_first <= {r_s, r_a, r_b};
                    end
                    // The last vector stays on the adder pins after the run.
                    if (w_last_vec) begin
                        r_pass <= (w_err_nxt == '0);
                    end else begin
                        {r_s, r_a, r_b} <= w_vec_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_first_fail = r_first;
    assign o_dut_a      = r_a;
    assign o_dut_b      = r_b;
    assign o_dut_s      = r_s;

endmodule

// File: doc/rca_bist.md
# rca_bist

Built-in self-test controller for the 4-bit ripple-carry adder/subtractor. It drives the adder's operand and mode inputs and checks its sum and carry outputs against an internal golden model, vector by vector. On a start pulse it sweeps every operand combination for the selected operation(s), counts mismatches and records the first failing vector. It is the stimulus-and-check end of the adder interface, synthesizable for on-chip use.

## Interface
- `WIDTH`, default 4: operand width of the adder under test.
- `SETTLE`, default 1: wait cycles between applying a vector and sampling the DUT (0 allowed).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `mode`  in  2  00 add only, 01 subtract only, 10 add then subtract, 11 treated as 10; sampled with `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  last completed run had zero mismatches.
- `err_count`  out  16  mismatches in current/last run, saturates at 0xFFFF.
- `first_fail`  out  2*WIDTH+1  {s,a,b} of first mismatch in run; meaningful only when `err_count` is not 0.
- `dut_a`, `dut_b`  out  WIDTH  registered operands to adder.
- `dut_s`  out  1  registered add(0)/subtract(1) select to adder.
- `dut_sum`  in  WIDTH  adder sum.
- `dut_cout`  in  1  adder carry out (c4).

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
  - IDLE → WAIT (or CHECK if SETTLE=0) on `start`=1.
  - WAIT → CHECK after SETTLE cycles.
  - CHECK → WAIT/CHECK for the next vector, or DONE after the last vector.
  - DONE → IDLE unconditionally.
- Vector counter {s,a,b}:
  - `b` is the innermost field, then `a`, then `s`.
  - Each field counts 0 upward.
  - Mode 00 sweeps s=0, 2^(2W) vectors. Mode 01 sweeps s=1, 2^(2W) vectors. Mode 10 sweeps s=0 then s=1, 2^(2W+1) vectors.
- On the start edge:
  - The first vector loads into `dut_a/b/s`.
  - `err_count` clears to 0, `pass` clears to 0, `first_fail` clears to 0.
- Golden model, computed WIDTH+1 bits wide:
  - s=0: {cout,sum} = a + b.
  - s=1: {cout,sum} = a + ~b + 1. So sum = (a−b) mod 2^W, and cout=1 iff a ≥ b unsigned.
- On the CHECK edge:
  - Compare `dut_sum`/`dut_cout` with the golden value for the vector currently driven. Any bit difference is a mismatch.
  - On a mismatch, increment `err_count` (saturating). If it was 0, capture {s,a,b} into `first_fail`.
  - Load the next vector on the same edge.
- Entering DONE:
  - `pass` <= (final `err_count` == 0).
  - `pass`, `err_count` and `first_fail` then hold until the next start or reset.
- Boundary conditions:
  - `start` in WAIT, CHECK or DONE is ignored.
  - `mode` changes mid-run are ignored.
  - A mismatch on the final vector is counted before `pass` is computed.
  - After the last vector, `dut_a/b/s` hold the last vector's values.
- Reset, including mid-run: all outputs return to reset values immediately, the FSM returns to IDLE, and no `done` pulse is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `dut_a`=0, `dut_b`=0, `dut_s`=0.
- All outputs are registered. DUT inputs are combinational from the DUT and sampled only on CHECK edges.
- Start edge at cycle 0:
  - `busy`=1 from cycle 1 through the last CHECK cycle.
  - Each vector occupies SETTLE+1 cycles.
  - `done`=1 for exactly one cycle, at cycle N·(SETTLE+1)+1, where N is the vector count. `busy`=0 in that cycle.
- Example, WIDTH=4, SETTLE=1: mode 00 asserts `done` at cycle 513; mode 10 asserts `done` at cycle 1025.
- Earliest next accepted `start` is in the cycle after `done`.

## Test plan
- Reset: assert `rst` for 3 cycles with no clock edges → all outputs match the reset values immediately (asynchronous).
- Ideal behavioural adder, mode 00, SETTLE=1 → `busy` is high for 512 cycles, `done` pulses at cycle 513, `pass`=1, `err_count`=0.
- Adder with `sum[2]` stuck at 0, mode 00 → `err_count`=128, `first_fail`=9'b0_0000_0100, `pass`=0.
- Adder with inverted `dut_cout`, mode 01 → `err_count`=256, `first_fail`=9'b1_0000_0000. Also check that golden is checked at a=7, b=14, s=1 as sum=9, cout=0.
- Mode 10, ideal adder, pulse `start` again at cycles 5 and 600:
  - Both extra pulses are ignored; a single `done` pulse occurs at cycle 1025 with `pass`=1.
  - Spot check: a=6, b=12, s=0 expects sum=2, cout=1; a=2, b=9, s=1 expects sum=9, cout=0.
- Assert `rst` during vector 100 → outputs are at reset values in the same cycle and no `done` pulse occurs. A fresh `start` then completes normally with `pass`=1.
